hs_src_feeder: RTL and testbench

Source-domain (sclk) transmitter that feeds the handshake synchronizer's source port. Buffers incoming words in a small FIFO and issues each one to the synchronizer via a single-cycle `sready` pulse with `din`, only when `sidle` reports the synchronizer free. It then waits for the full transfer to complete before issuing the next word. Sits between the clk1 producer logic and the handshake synchronizer.

---
 rtl/hs_src_feeder.sv | 120 ++++++++++++
 tb/tb_hs_src_feeder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_src_feeder.sv
// Source-side feeder for the handshake synchronizer: FIFO-buffers producer words and issues one per full handshake.
// Optional watchdog built when HS_FEEDER_TIMEOUT_EN is defined.
module hs_src_feeder #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             sidle,
  output logic             sready,
  output logic [WIDTH-1:0] din,
  output logic             busy,
  output logic [15:0]      sent_cnt,
  output logic             err
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_LOW, S_WAIT_HIGH} state_t;

  state_t                      state, state_nxt;
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [AW:0]                 count;
  logic                        push, issue;

  assign in_ready = (count < (AW+1)'(DEPTH));
  assign push     = in_valid & in_ready;

  // state register
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (issue) state_nxt = S_ISSUE;
      S_ISSUE:     state_nxt = S_WAIT_LOW;
      S_WAIT_LOW:  if (!sidle) state_nxt = S_WAIT_HIGH;
      S_WAIT_HIGH: if (sidle) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // outputs / decodes
  always_comb begin
    issue = (state == S_IDLE) && (count != '0) && sidle;
    busy  = (state != S_IDLE) || (count != '0);
  end

  // storage is not reset; reset only discards it through the pointers
  always_ff @(posedge sclk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      case ({push, issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      sready   <= 1'b0;
      din      <= '0;
      sent_cnt <= '0;
    end else begin
      sready <= issue;
      if (issue) begin
        din      <= mem[rd_ptr];
        sent_cnt <= sent_cnt + 16'd1;
      end
    end
  end

`ifdef HS_FEEDER_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        err_q;
  logic        waiting;

  assign waiting = (state == S_WAIT_LOW) || (state == S_WAIT_HIGH);

  // err rises on the edge where wd_cnt reaches TIMEOUT; transfer is never aborted
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == S_ISSUE)
        wd_cnt <= '0;
      else if (waiting && (wd_cnt < 16'(TIMEOUT)))
        wd_cnt <= wd_cnt + 16'd1;
      if (waiting && (wd_cnt >= 16'(TIMEOUT - 1)))
        err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  // no watchdog: constant 0
  assign err = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_hs_src_feeder.sv
// Randomized bench for hs_src_feeder: queue-based reference model checked every cycle, plus directed literal checks.
module tb_hs_src_feeder;
  localparam int WIDTH   = 8;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 20;

  logic             sclk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             sidle = 1'b1;
  logic             in_ready, sready, busy, err;
  logic [WIDTH-1:0] din;
  logic [15:0]      sent_cnt;

  hs_src_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .sclk(sclk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .sidle(sidle), .sready(sready), .din(din),
    .busy(busy), .sent_cnt(sent_cnt), .err(err)
  );

  always #5 sclk = ~sclk;

  int n_vec = 0, n_miss = 0, n_cmp = 0;

  // reference model: queue of buffered words plus "transfer in flight" bookkeeping
  logic [WIDTH-1:0] q[$];
  bit               m_fly, m_low_seen, m_sready, m_err;
  int               m_age, m_wd;
  logic [WIDTH-1:0] m_din;
  logic [15:0]      m_sent;

  // synchronizer stand-in and observation log
  bit               hold_low = 1'b0;
  int               sync_ph = 0, low_left = 0, k_min = 1, k_max = 6;
  logic [WIDTH-1:0] seen[$];
  logic [WIDTH-1:0] exp_words[$];
  int               pulses = 0;
  bit               last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    int sz;
    bit push, issue;
    if (!rst_n) begin
      q.delete();
      m_fly = 0; m_low_seen = 0; m_sready = 0; m_err = 0;
      m_age = 0; m_wd = 0; m_din = '0; m_sent = '0;
      return;
    end
    sz    = q.size();
    push  = in_valid && (sz < DEPTH);
    issue = !m_fly && (sz != 0) && sidle;
    if (m_fly) begin
      if (m_age == 0) begin
        // the cycle sready is high: sidle is not looked at
        m_age = 1; m_low_seen = 0; m_wd = 0;
      end else begin
        if (m_wd < TIMEOUT) m_wd++;
`ifdef HS_FEEDER_TIMEOUT_EN
        if (m_wd >= TIMEOUT) m_err = 1;
`endif
        if (!m_low_seen) begin
          if (!sidle) m_low_seen = 1;
        end else if (sidle) begin
          m_fly = 0;
        end
      end
    end
    m_sready = issue;
    if (issue) begin
      m_din = q.pop_front();
      m_sent++;
      m_fly = 1;
      m_age = 0;
    end
    if (push) q.push_back(in_data);
  endtask

  task automatic compare();
    chk("sready",   sready,   m_sready);
    chk("din",      din,      m_din);
    chk("sent_cnt", sent_cnt, m_sent);
    chk("in_ready", in_ready, q.size() < DEPTH);
    chk("busy",     busy,     m_fly || (q.size() != 0));
    chk("err",      err,      m_err);
  endtask

  // one clock: drive sidle at negedge, step model at posedge, compare just after
  task automatic cycle();
    @(negedge sclk);
    if (sync_ph == 1) begin
      sidle = 1'b1; sync_ph = 2;
    end else if (sync_ph == 2) begin
      sidle = 1'b0; low_left--;
      if (low_left <= 0) sync_ph = 0;
    end else begin
      sidle = 1'b1;
    end
    if (hold_low) sidle = 1'b0;
    last_acc = rst_n && in_valid && in_ready;
    @(posedge sclk);
    model_step();
    #1;
    compare();
    n_vec++;
    if (sready === 1'b1) begin
      pulses++;
      seen.push_back(din);
      sync_ph  = 1;
      low_left = $urandom_range(k_max, k_min);
    end
    if (!rst_n) sync_ph = 0;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      cycle();
      ok = last_acc;
    end
    in_valid = 1'b0;
    if (!ok) chk("push_timeout", ok, 1);
  endtask

  task automatic wait_pulses(input int n, input int budget);
    for (int i = 0; i < budget && pulses < n; i++) cycle();
    if (pulses < n) chk("pulse_timeout", pulses, n);
  endtask

  initial begin
    int d, nw;

    // reset with random inputs
    rst_n = 1'b0;
    repeat (4) begin
      in_valid = $urandom; in_data = $urandom; hold_low = $urandom;
      cycle();
    end
    chk("rst_sready", sready, 0);
    chk("rst_din", din, 0);
    chk("rst_sent", sent_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    in_valid = 1'b0; hold_low = 1'b0; rst_n = 1'b1;
    repeat (2) cycle();

    // single word, synchronizer low for 6 cycles
    k_min = 6; k_max = 6; pulses = 0; seen.delete();
    push_word(8'hA5);
    repeat (20) cycle();
    chk("sw_pulses", pulses, 1);
    chk("sw_din", seen[0], 8'hA5);
    chk("sw_sent", sent_cnt, 1);
    chk("sw_busy", busy, 0);

    // backpressure: synchronizer held busy while 9 words are offered
    k_min = 1; k_max = 4; hold_low = 1'b1; pulses = 0; seen.delete();
    d = 1; in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_data = d[WIDTH-1:0];
      cycle();
      if (last_acc) d++;
    end
    chk("bp_in_ready", in_ready, 0);
    chk("bp_held_word", d, 9);
    hold_low = 1'b0;
    for (int i = 0; i < 300 && pulses < 9; i++) begin
      in_data = d[WIDTH-1:0];
      cycle();
      if (last_acc) begin
        d++;
        if (d > 9) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("bp_pulses", pulses, 9);
    for (int i = 0; i < 9; i++) chk("bp_order", seen[i], i + 1);
    repeat (10) cycle();

    // random traffic: 100 words against the scoreboard
    k_min = 1; k_max = 6; pulses = 0; seen.delete(); exp_words.delete(); nw = 0;
    for (int i = 0; i < 4000 && (nw < 100 || busy); i++) begin
      if (!in_valid && nw < 100 && $urandom_range(3, 0) != 0) begin
        in_valid = 1'b1; in_data = $urandom;
      end
      hold_low = ($urandom_range(7, 0) == 0);
      cycle();
      if (last_acc) begin
        exp_words.push_back(in_data);
        nw++;
        in_valid = 1'b0;
      end
    end
    hold_low = 1'b0; in_valid = 1'b0;
    chk("rnd_pulses", pulses, 100);
    for (int i = 0; i < 100; i++) chk("rnd_order", seen[i], exp_words[i]);

    // reset in the middle of a transfer with words queued
    k_min = 8; k_max = 8; pulses = 0; seen.delete();
    for (int w = 0; w < 5; w++) push_word(8'h10 + w[WIDTH-1:0]);
    repeat (2) cycle();
    chk("mr_pre_busy", busy, 1);
    rst_n = 1'b0;
    repeat (3) begin
      in_valid = $urandom; in_data = $urandom; hold_low = $urandom;
      cycle();
    end
    chk("mr_sready", sready, 0);
    chk("mr_din", din, 0);
    chk("mr_sent", sent_cnt, 0);
    chk("mr_in_ready", in_ready, 1);
    chk("mr_busy", busy, 0);
    in_valid = 1'b0; hold_low = 1'b0; rst_n = 1'b1; pulses = 0; seen.delete();
    repeat (20) cycle();
    chk("mr_no_pulse", pulses, 0);
    k_min = 3; k_max = 3;
    push_word(8'h3C);
    wait_pulses(1, 20);
    chk("mr_new_din", seen[0], 8'h3C);
    chk("mr_new_sent", sent_cnt, 1);
    repeat (10) cycle();

    // watchdog: synchronizer stays busy for 30 cycles after an issue
    chk("wd_pre_err", err, 0);
    k_min = 30; k_max = 30; pulses = 0;
    push_word(8'h77);
    wait_pulses(1, 20);
    repeat (40) cycle();
`ifdef HS_FEEDER_TIMEOUT_EN
    chk("wd_err", err, 1);
`else
    chk("wd_err", err, 0);
`endif
    chk("wd_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
